// File: rtl/game_input_ctrl.sv
// game_input_ctrl
//   Player-input front end. Two-flop synchronises the five push-buttons and
//   the slide switches, debounces each button, and produces one-cycle press
//   pulses. Direction buttons auto-repeat while held. Owns the top-level
//   game-mode FSM that selects which game core is enabled.
//
// Ports
//   clk                  system clock, rising edge
//   clr                  synchronous active-high reset
//   btn[4:0]             raw buttons: 0 up, 1 down, 2 left, 3 right, 4 centre
//   sw[4:0]              raw switches: 0 abort, 1 game select, 4:2 pass-through
//   game_over_classic    one-cycle pulse from the classic core
//   game_over_infinity   one-cycle pulse from the infinity core
//   btn_level[4:0]       debounced button state
//   btn_pulse[4:0]       one-cycle press pulse (plus auto-repeat on [3:0])
//   sw_sync[4:0]         synchronised switches
//   mode[2:0]            0 MENU, 1 CLASSIC, 2 INFINITY, 3 RESULT
//   enable_game_classic  high only in CLASSIC
//   enable_game_infinity high only in INFINITY
module game_input_ctrl #(
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int REPEAT_DELAY    = 50_000_000,
  parameter int REPEAT_RATE     = 10_000_000
) (
  input  logic       clk,
  input  logic       clr,
  input  logic [4:0] btn,
  input  logic [4:0] sw,
  input  logic       game_over_classic,
  input  logic       game_over_infinity,
  output logic [4:0] btn_level,
  output logic [4:0] btn_pulse,
  output logic [4:0] sw_sync,
  output logic [2:0] mode,
  output logic       enable_game_classic,
  output logic       enable_game_infinity
);

  localparam int DW   = $clog2(DEBOUNCE_CYCLES);
  localparam int RMAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int RW   = (RMAX > 1) ? $clog2(RMAX) : 1;

  localparam logic [DW-1:0] DEB_MAX   = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [RW-1:0] DELAY_MAX = RW'(REPEAT_DELAY - 1);
  localparam logic [RW-1:0] RATE_MAX  = RW'(REPEAT_RATE - 1);

  typedef enum logic [1:0] {
    MENU     = 2'd0,
    CLASSIC  = 2'd1,
    INFINITY = 2'd2,
    RESULT   = 2'd3
  } mode_t;

  // Synchronisers
  logic [4:0] btn_m;
  logic [4:0] btn_s;
  logic [4:0] sw_m;

  always_ff @(posedge clk) begin
    if (clr) begin
      btn_m   <= '0;
      btn_s   <= '0;
      sw_m    <= '0;
      sw_sync <= '0;
    end else begin
      btn_m   <= btn;
      btn_s   <= btn_m;
      sw_m    <= sw;
      sw_sync <= sw_m;
    end
  end

  // Debounce
  logic [DW-1:0] deb_cnt     [5];
  logic [DW-1:0] deb_cnt_nxt [5];
  logic [4:0]    level_nxt;
  logic [4:0]    rise;

  always_comb begin
    level_nxt = btn_level;
    for (int unsigned i = 0; i < 5; i++) begin
      deb_cnt_nxt[i] = '0;
      if (btn_s[i] != btn_level[i]) begin
        if (deb_cnt[i] == DEB_MAX) begin
          level_nxt[i] = btn_s[i];
        end else begin
          deb_cnt_nxt[i] = deb_cnt[i] + DW'(1);
        end
      end
    end
    rise = level_nxt & ~btn_level;
  end

  // Auto-repeat for the four direction buttons. The hold counter is evaluated
  // against the next level so a release and a due repeat landing on the same
  // edge never emit a pulse. rep_phase selects the initial delay (0) or the
  // steady repeat interval (1).
  logic [RW-1:0] rep_cnt       [4];
  logic [RW-1:0] rep_cnt_nxt   [4];
  logic [3:0]    rep_phase;
  logic [3:0]    rep_phase_nxt;
  logic [3:0]    rep_fire;

  always_comb begin
    rep_phase_nxt = '0;
    rep_fire      = '0;
    for (int unsigned i = 0; i < 4; i++) begin
      rep_cnt_nxt[i] = '0;
      if (level_nxt[i] && !rise[i]) begin
        if (rep_cnt[i] == (rep_phase[i] ? RATE_MAX : DELAY_MAX)) begin
          rep_fire[i]      = 1'b1;
          rep_phase_nxt[i] = 1'b1;
        end else begin
          rep_cnt_nxt[i]   = rep_cnt[i] + RW'(1);
          rep_phase_nxt[i] = rep_phase[i];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      btn_level <= '0;
      btn_pulse <= '0;
      rep_phase <= '0;
      for (int unsigned i = 0; i < 5; i++) deb_cnt[i] <= '0;
      for (int unsigned i = 0; i < 4; i++) rep_cnt[i] <= '0;
    end else begin
      btn_level <= level_nxt;
      btn_pulse <= rise | {1'b0, rep_fire};
      rep_phase <= rep_phase_nxt;
      for (int unsigned i = 0; i < 5; i++) deb_cnt[i] <= deb_cnt_nxt[i];
      for (int unsigned i = 0; i < 4; i++) rep_cnt[i] <= rep_cnt_nxt[i];
    end
  end

  // Mode FSM
  mode_t state;
  mode_t state_nxt;

  always_ff @(posedge clk) begin
    if (clr) state <= MENU;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      MENU:     if (btn_pulse[4]) state_nxt = sw_sync[1] ? INFINITY : CLASSIC;
      CLASSIC:  if (game_over_classic) state_nxt = RESULT;
      INFINITY: if (game_over_infinity) state_nxt = RESULT;
      RESULT:   if (btn_pulse[4]) state_nxt = MENU;
      default:  state_nxt = MENU;
    endcase
    // Abort overrides every other transition and holds MENU while set.
    if (sw_sync[0]) state_nxt = MENU;
  end

  assign mode                 = {1'b0, state};
  assign enable_game_classic  = (state == CLASSIC);
  assign enable_game_infinity = (state == INFINITY);

endmodule
